// File: rtl/ram2p_pkg.sv
// Shared types and constants for the ram2p two-port byte-lane RAM.
package ram2p_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram2p_lane.sv
// One byte lane of the ram2p array: synchronous write, asynchronous read.
module ram2p_lane #(
    parameter int AWIDTH = 3,
    parameter int BWIDTH = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [BWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [BWIDTH-1:0] rdata
);

    logic [BWIDTH-1:0] mem_q [2**AWIDTH];

    // Storage is intentionally not reset; clearing is the top level's job.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram2p.sv
// Two-port RAM with per-lane write enables, registered read and optional
// post-reset zero sweep (enabled by defining RAM2P_CLEAR_EN).
module ram2p
    import ram2p_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 3,
    parameter int BWIDTH   = 8,
    parameter int RDW_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [AWIDTH-1:0]          waddr,
    input  logic [DWIDTH-1:0]          wdata,
    input  logic [DWIDTH/BWIDTH-1:0]   wbe,
    input  logic                       re,
    input  logic [AWIDTH-1:0]          raddr,
    output logic [DWIDTH-1:0]          rdata,
    output logic                       rvalid,
    output logic                       ready
);

    localparam int NLANES = DWIDTH / BWIDTH;

    state_e              state_q, state_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                ready_s, wr_acc_s, rd_acc_s;
    logic [NLANES-1:0]   lane_we_s;
    logic [AWIDTH-1:0]   lane_addr_s;
    logic [DWIDTH-1:0]   lane_wdata_s;
    logic [DWIDTH-1:0]   mem_rd_s;
    logic [DWIDTH-1:0]   fwd_s;

    assign ready_s  = (state_q == READY);
    assign wr_acc_s = we & ready_s;
    assign rd_acc_s = re & ready_s;

`ifdef RAM2P_CLEAR_EN
    localparam logic [AWIDTH-1:0] TOP_ADDR = {AWIDTH{1'b1}};
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    // Next state: leave CLEAR once the top address has been swept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   state_d = (cnt_q == TOP_ADDR) ? READY : CLEAR;
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Sweep counter parks on the top address instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == CLEAR) && (cnt_q != TOP_ADDR)) begin
            cnt_d = cnt_q + {{(AWIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sweep counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {AWIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Next state: no sweep, go straight to READY.
    always_comb begin
        state_d = READY;
    end
`endif

    // Write port mux; rst_n gating keeps reset itself from touching the array.
    always_comb begin
        lane_addr_s  = waddr;
        lane_wdata_s = wdata;
        lane_we_s    = wbe & {NLANES{wr_acc_s & rst_n}};
`ifdef RAM2P_CLEAR_EN
        if (state_q == CLEAR) begin
            lane_addr_s  = cnt_q;
            lane_wdata_s = {DWIDTH{1'b0}};
            lane_we_s    = {NLANES{rst_n}};
        end else begin
            lane_addr_s  = waddr;
        end
`endif
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        ram2p_lane #(
            .AWIDTH (AWIDTH),
            .BWIDTH (BWIDTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we_s[i]),
            .waddr (lane_addr_s),
            .wdata (lane_wdata_s[i*BWIDTH +: BWIDTH]),
            .raddr (raddr),
            .rdata (mem_rd_s[i*BWIDTH +: BWIDTH])
        );
    end

    // Same-address forwarding of freshly written lanes when RDW_MODE is new-data.
    always_comb begin
        fwd_s = mem_rd_s;
        for (int i = 0; i < NLANES; i++) begin
            if ((RDW_MODE == RDW_NEW) && wr_acc_s && wbe[i] && (waddr == raddr)) begin
                fwd_s[i*BWIDTH +: BWIDTH] = wdata[i*BWIDTH +: BWIDTH];
            end else begin
                fwd_s[i*BWIDTH +: BWIDTH] = mem_rd_s[i*BWIDTH +: BWIDTH];
            end
        end
    end

    // Output next values: rdata holds when no read is accepted.
    always_comb begin
        rvalid_d = rd_acc_s;
        if (rd_acc_s) begin
            rdata_d = fwd_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            rdata_q  <= {DWIDTH{1'b0}};
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ready  = ready_s;

endmodule

// File: doc/ram2p.md
RAM2P -- requirements
Module: ram2p

Interface
REQ-001 Parameter DWIDTH, default 16, data width in bits; SHALL be a multiple of BWIDTH.
REQ-002 Parameter AWIDTH, default 3, address width; depth = 2**AWIDTH words.
REQ-003 Parameter BWIDTH, default 8, byte-lane width; NLANES = DWIDTH/BWIDTH.
REQ-004 Parameter RDW_MODE, default 0, same-address read-during-write: 0 returns old data, 1 returns new data per written lane.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 we  input  1  write request, honoured only while ready=1.
REQ-008 waddr  input  AWIDTH  write address.
REQ-009 wdata  input  DWIDTH  write data.
REQ-010 wbe  input  NLANES  per-lane write enable; lane i covers bits [i*BWIDTH +: BWIDTH].
REQ-011 re  input  1  read request, honoured only while ready=1.
REQ-012 raddr  input  AWIDTH  read address.
REQ-013 rdata  output  DWIDTH  registered read data.
REQ-014 rvalid  output  1  high for exactly the cycle in which rdata holds the result of an accepted read.
REQ-015 ready  output  1  high when the array accepts reads and writes.

Function
REQ-016 Write: on a clk edge with ready=1 and we=1, each lane i with wbe[i]=1 SHALL be updated from wdata; lanes with wbe[i]=0 SHALL keep their contents.
REQ-017 Read latency SHALL be one cycle: re=1 sampled at edge N puts data in rdata and rvalid=1 after edge N, through edge N+1.
REQ-018 With no accepted read, rdata SHALL hold its previous value and rvalid SHALL be 0.
REQ-019 Read and write to different addresses in the same cycle SHALL both complete without interaction.
REQ-020 Same-address read and write, RDW_MODE=0: rdata SHALL be the pre-write contents of all lanes.
REQ-021 Same-address read and write, RDW_MODE=1: lanes with wbe=1 SHALL return wdata, lanes with wbe=0 the stored value.
REQ-022 FSM states: CLEAR (sweeping), READY. CLEAR->READY when the sweep counter writes address 2**AWIDTH-1; READY is terminal until reset.
REQ-023 In CLEAR, we and re SHALL be ignored, ready=0, rvalid=0; the counter writes zero to all lanes of one address per cycle, from 0 upward.
REQ-024 The sweep counter is AWIDTH bits; it SHALL NOT wrap back into CLEAR after reaching the top address.

Reset
REQ-025 While rst_n=0: ready=0, rvalid=0, rdata=0, sweep counter=0, state=CLEAR (or READY per REQ-027); array contents are not altered by reset itself.
REQ-026 Reset asserted mid-sweep or mid-read SHALL abort it immediately; on release the sweep restarts from address 0, and no rvalid is produced for the aborted read.

Configuration
REQ-027 Macro RAM2P_CLEAR_EN: defined -> CLEAR sweep per REQ-022..024, ready rises 2**AWIDTH cycles after rst_n release; undefined -> no sweep logic, state leaves reset directly into READY, ready=1 on the first edge after release, array contents undefined until written.

Structure
REQ-028 Package ram2p_pkg SHALL hold the state enum (CLEAR, READY) and the RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
REQ-029 Sub-module ram2p_lane SHALL implement one BWIDTH-wide lane array with own write enable; ram2p instantiates NLANES copies and holds FSM, counter, forwarding mux, and output registers.

Verification (DWIDTH=16, AWIDTH=3, BWIDTH=8, RAM2P_CLEAR_EN defined unless stated)
REQ-030 Release rst_n -> ready=0 for 8 cycles, then 1; read all 8 addresses -> 0x0000 each, rvalid one cycle after each re.
REQ-031 Write addr 2 = 0xA5A5 wbe=11, then addr 2 = 0x3C00 wbe=10, read 2 -> 0x3CA5.
REQ-032 Addr 4 holds 0x1111; same-cycle write 0x2222 wbe=01 and read addr 4 -> RDW_MODE=0: 0x1111; RDW_MODE=1: 0x1122; later read -> 0x1122.
REQ-033 Pulse rst_n low at sweep address 5 -> sweep restarts at 0, ready asserts 8 cycles after release; we/re during sweep leave no effect and rvalid stays 0.
REQ-034 RAM2P_CLEAR_EN undefined -> ready=1 first edge after release; write addr 7 = 0xBEEF, read 7 -> 0xBEEF in 1 cycle.
REQ-035 Simultaneous write addr 0 = 0x0F0F and read addr 1 (holding 0x1234) -> rdata 0x1234, then read 0 -> 0x0F0F.
